// File: rtl/alu_regfile_datapath.sv
// 8x16 register file (2 async read, 1 sync write) feeding operand muxes and an 8-function ALU.
// Latency: reads, muxes and ALU are combinational; a write is visible one rising edge later.
// Backpressure: none; every input is consumed each cycle and the write port never stalls.
module alu_regfile_datapath #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd0_addr,
    input  logic [AW-1:0]     rd1_addr,
    input  logic              alusrc1,
    input  logic              alusrc2,
    input  logic [DATA_W-1:0] imm,
    input  logic [2:0]        s,
    output logic [DATA_W-1:0] rd0_data,
    output logic [DATA_W-1:0] rd1_data,
    output logic [DATA_W-1:0] f,
    output logic              ovf,
    output logic              take_branch
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;

    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic [3:0]        shamt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // No write bypass: a same-cycle write shows up only after the edge.
    assign rd0_data = regs[rd0_addr];
    assign rd1_data = regs[rd1_addr];

    assign op_a  = alusrc1 ? '0 : rd0_data;
    assign op_b  = alusrc2 ? imm : rd1_data;
    assign sum   = op_a + op_b;
    assign diff  = op_a - op_b;
    assign shamt = op_b[3:0];

    always_comb begin
        f   = '0;
        ovf = 1'b0;
        case (s)
            OP_ADD: begin
                f   = sum;
                ovf = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (sum[DATA_W-1] != op_a[DATA_W-1]);
            end
            OP_SUB: begin
                f   = diff;
                ovf = (op_a[DATA_W-1] != op_b[DATA_W-1]) && (diff[DATA_W-1] != op_a[DATA_W-1]);
            end
            OP_AND: f = op_a & op_b;
            OP_OR:  f = op_a | op_b;
            OP_XOR: f = op_a ^ op_b;
            OP_SLT: f = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLL: f = op_a << shamt;
            OP_SRL: f = op_a >> shamt;
            default: f = '0;
        endcase
    end

    // Zero result doubles as the branch condition (SUB of equal operands = beq).
    assign take_branch = (f == '0);

endmodule

// File: tb/tb_alu_regfile_datapath.sv
// Directed plus random stimulus for alu_regfile_datapath against an arithmetic reference model.
module tb_alu_regfile_datapath;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [2:0]  rd0_addr = '0;
    logic [2:0]  rd1_addr = '0;
    logic        alusrc1 = 1'b0;
    logic        alusrc2 = 1'b0;
    logic [15:0] imm = '0;
    logic [2:0]  s = '0;
    logic [15:0] rd0_data;
    logic [15:0] rd1_data;
    logic [15:0] f;
    logic        ovf;
    logic        take_branch;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] mregs [8];

    alu_regfile_datapath dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd0_addr(rd0_addr), .rd1_addr(rd1_addr), .alusrc1(alusrc1), .alusrc2(alusrc2),
        .imm(imm), .s(s), .rd0_data(rd0_data), .rd1_data(rd1_data), .f(f), .ovf(ovf),
        .take_branch(take_branch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference ALU in signed integer arithmetic; overflow = result outside 16-bit signed range.
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                         output logic [15:0] fe, output logic ov);
        int sa, sb, r, sh;
        sa = int'($signed(a));
        sb = int'($signed(b));
        sh = int'(b % 16'd16);
        r  = 0;
        ov = 1'b0;
        fe = '0;
        case (op)
            3'd0: begin r = sa + sb; ov = (r > 32767) || (r < -32768); fe = r[15:0]; end
            3'd1: begin r = sa - sb; ov = (r > 32767) || (r < -32768); fe = r[15:0]; end
            3'd2: fe = a & b;
            3'd3: fe = a | b;
            3'd4: fe = a ^ b;
            3'd5: fe = (sa < sb) ? 16'd1 : 16'd0;
            3'd6: begin r = int'(a) * (2 ** sh); fe = r[15:0]; end
            default: begin r = int'(a) / (2 ** sh); fe = r[15:0]; end
        endcase
    endtask

    task automatic check_all(input string tag);
        logic [15:0] a, b, fe;
        logic ov;
        a = alusrc1 ? 16'h0000 : mregs[rd0_addr];
        b = alusrc2 ? imm : mregs[rd1_addr];
        model(a, b, s, fe, ov);
        chk({tag, "_rd0"}, rd0_data, mregs[rd0_addr]);
        chk({tag, "_rd1"}, rd1_data, mregs[rd1_addr]);
        chk({tag, "_f"}, f, fe);
        chk({tag, "_ovf"}, {15'b0, ovf}, {15'b0, ov});
        chk({tag, "_br"}, {15'b0, take_branch}, {15'b0, fe == 16'h0000});
    endtask

    task automatic set_ops(input logic a1, input logic a2, input logic [15:0] im,
                           input logic [2:0] op, input logic [2:0] r0, input logic [2:0] r1);
        alusrc1 = a1; alusrc2 = a2; imm = im; s = op; rd0_addr = r0; rd1_addr = r1;
        #1;
    endtask

    task automatic write_reg(input logic [2:0] addr, input logic [15:0] data);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = addr; wr_data = data;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        if (rst) mregs[addr] = data;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mregs[i] = '0;

        // Reset state
        set_ops(1'b0, 1'b0, 16'h0, 3'd0, 3'd5, 3'd6);
        chk("rst_rd0", rd0_data, 16'h0);
        chk("rst_rd1", rd1_data, 16'h0);
        chk("rst_f", f, 16'h0);
        chk("rst_ovf", {15'b0, ovf}, 16'h0);
        chk("rst_br", {15'b0, take_branch}, 16'h1);
        #12;
        rst = 1'b1;

        // Immediate path written back
        @(negedge clk);
        set_ops(1'b1, 1'b1, 16'd15, 3'd0, 3'd0, 3'd0);
        chk("imm15_f", f, 16'd15);
        write_reg(3'd2, f);
        set_ops(1'b1, 1'b1, 16'd17, 3'd0, 3'd2, 3'd0);
        chk("r2_15", rd0_data, 16'd15);
        write_reg(3'd3, f);
        set_ops(1'b0, 1'b0, 16'd0, 3'd0, 3'd2, 3'd3);
        chk("add_r2r3_f", f, 16'd32);
        chk("add_r2r3_ovf", {15'b0, ovf}, 16'h0);
        check_all("add_r2r3");

        // r0 is writable
        write_reg(3'd0, 16'd90);
        set_ops(1'b0, 1'b1, 16'd9, 3'd0, 3'd0, 3'd0);
        chk("r0_add_f", f, 16'd99);
        set_ops(1'b1, 1'b0, 16'd9, 3'd0, 3'd0, 3'd2);
        chk("zeroA_f", f, 16'd15);

        // Overflow and branch-if-equal
        write_reg(3'd4, 16'h7FFF);
        set_ops(1'b0, 1'b1, 16'd1, 3'd0, 3'd4, 3'd0);
        chk("addovf_f", f, 16'h8000);
        chk("addovf_ovf", {15'b0, ovf}, 16'h1);
        write_reg(3'd5, 16'h8000);
        set_ops(1'b0, 1'b1, 16'd1, 3'd1, 3'd5, 3'd0);
        chk("subovf_f", f, 16'h7FFF);
        chk("subovf_ovf", {15'b0, ovf}, 16'h1);
        write_reg(3'd6, 16'h1234);
        set_ops(1'b0, 1'b0, 16'd0, 3'd1, 3'd6, 3'd6);
        chk("beq_f", f, 16'h0);
        chk("beq_br", {15'b0, take_branch}, 16'h1);

        // Remaining ops
        write_reg(3'd7, 16'hF0F0);
        set_ops(1'b0, 1'b1, 16'h0FF0, 3'd2, 3'd7, 3'd0);
        chk("and_f", f, 16'h00F0);
        set_ops(1'b0, 1'b1, 16'h0FF0, 3'd3, 3'd7, 3'd0);
        chk("or_f", f, 16'hFFF0);
        set_ops(1'b0, 1'b1, 16'h0FF0, 3'd4, 3'd7, 3'd0);
        chk("xor_f", f, 16'hFF00);
        chk("xor_br", {15'b0, take_branch}, 16'h0);
        write_reg(3'd1, 16'hFFFF);
        set_ops(1'b0, 1'b1, 16'd1, 3'd5, 3'd1, 3'd0);
        chk("slt_f", f, 16'd1);
        set_ops(1'b0, 1'b1, 16'hFFFF, 3'd5, 3'd2, 3'd0);
        chk("slt_neg_f", f, 16'd0);
        write_reg(3'd3, 16'd1);
        set_ops(1'b0, 1'b1, 16'h0013, 3'd6, 3'd3, 3'd0);
        chk("sll_f", f, 16'h0008);
        set_ops(1'b0, 1'b1, 16'd15, 3'd7, 3'd5, 3'd0);
        chk("srl_f", f, 16'h0001);

        // Read-during-write: old value until the edge, new value after
        @(negedge clk);
        set_ops(1'b0, 1'b0, 16'h0, 3'd0, 3'd4, 3'd4);
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'hBEEF;
        #1;
        chk("rdw_old", rd0_data, 16'h7FFF);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        mregs[4] = 16'hBEEF;
        chk("rdw_new", rd1_data, 16'hBEEF);

        // Random traffic against the model
        for (int it = 0; it < 300; it++) begin
            @(negedge clk);
            if ($urandom_range(0, 2) == 0) begin
                write_reg(3'($urandom_range(0, 7)), 16'($urandom));
            end
            set_ops(1'($urandom), 1'($urandom), 16'($urandom), 3'($urandom),
                    3'($urandom), 3'($urandom));
            check_all("rand");
        end

        // Mid-cycle asynchronous reset, then writes ignored while held
        @(negedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) mregs[i] = '0;
        for (int i = 0; i < 8; i++) begin
            rd0_addr = 3'(i);
            rd1_addr = 3'(7 - i);
            #1;
            chk("midrst_rd0", rd0_data, 16'h0);
            chk("midrst_rd1", rd1_data, 16'h0);
        end
        write_reg(3'd2, 16'hAAAA);
        set_ops(1'b0, 1'b0, 16'h0, 3'd0, 3'd2, 3'd2);
        chk("rst_wr_ignored", rd0_data, 16'h0);
        chk("rst_hold_br", {15'b0, take_branch}, 16'h1);
        @(negedge clk);
        rst = 1'b1;
        write_reg(3'd2, 16'h5555);
        set_ops(1'b0, 1'b1, 16'h0001, 3'd0, 3'd2, 3'd2);
        check_all("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
